// File: rtl/vga_timing_monitor.sv
`timescale 1ns/1ps
// Sync-stream monitor: rebuilds raster coordinates and active video from HS/VS,
// measures line/frame/pulse timing against the nominal raster and tracks lock.
//   state   | meaning
//   SEARCH  | no frame reference yet, waiting for a VS fall
//   ACQUIRE | counting consecutive clean frames toward lock
//   LOCKED  | timing trusted; any error pulse drops back to SEARCH
module vga_timing_monitor #(
  parameter int HOR_SIZE    = 800,
  parameter int HOR_AL      = 640,
  parameter int HOR_FP      = 16,
  parameter int HOR_PW      = 96,
  parameter int VER_SIZE    = 521,
  parameter int VER_AF      = 480,
  parameter int VER_FP      = 10,
  parameter int VER_PW      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       ckVideo,
  input  logic       rstVideoN,
  input  logic       HS,
  input  logic       VS,
  output logic [9:0] adrHor,
  output logic [9:0] adrVer,
  output logic       flgActiveVideo,
  output logic       flgLocked,
  output logic       errHor,
  output logic       errVer,
  output logic [9:0] lineLen,
  output logic [9:0] frameLines
);

  localparam logic [9:0] SAT     = 10'h3FF;
  localparam logic [9:0] H_SIZE  = 10'(HOR_SIZE);
  localparam logic [9:0] H_AL    = 10'(HOR_AL);
  localparam logic [9:0] H_SYNC  = 10'(HOR_AL + HOR_FP);
  localparam logic [9:0] H_PW    = 10'(HOR_PW);
  localparam logic [9:0] V_SIZE  = 10'(VER_SIZE);
  localparam logic [9:0] V_AF    = 10'(VER_AF);
  localparam logic [9:0] V_SYNC  = 10'(VER_AF + VER_FP);
  localparam logic [9:0] V_PW    = 10'(VER_PW);
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state;
  logic       hsQ, vsQ;
  logic       hsFall, hsRise, vsFall, vsRise;
  logic [9:0] pcnt, pcntInc, hsWid, lcnt, vsWid;
  logic       firstH, toFired;
  logic [3:0] goodCnt, goodNext;
  logic       frameBad;
  logic       horEv, verEv, anyEv;

  assign hsFall   = hsQ & ~HS;
  assign hsRise   = ~hsQ & HS;
  assign vsFall   = vsQ & ~VS;
  assign vsRise   = ~vsQ & VS;
  assign pcntInc  = (pcnt == SAT) ? SAT : pcnt + 10'd1;
  assign goodNext = goodCnt + 4'd1;

  // The timeout term fires once per HS period; toFired re-arms on the next fall.
  assign horEv = (hsFall & firstH & (pcntInc != H_SIZE))
               | (hsRise & (hsWid != H_PW))
               | ((pcnt == SAT) & ~toFired);
  assign verEv = (vsFall & (state != SEARCH) & (lcnt != V_SIZE))
               | (vsRise & (vsWid != V_PW));
  assign anyEv = horEv | verEv;

  always_ff @(posedge ckVideo or negedge rstVideoN) begin
    if (!rstVideoN) begin
      hsQ    <= 1'b1;
      vsQ    <= 1'b1;
      errHor <= 1'b0;
      errVer <= 1'b0;
    end else begin
      hsQ    <= HS;
      vsQ    <= VS;
      errHor <= horEv;
      errVer <= verEv;
    end
  end

  always_ff @(posedge ckVideo or negedge rstVideoN) begin
    if (!rstVideoN) begin
      adrHor  <= '0;
      pcnt    <= '0;
      lineLen <= '0;
      hsWid   <= '0;
      firstH  <= 1'b0;
      toFired <= 1'b0;
    end else begin
      if (hsFall) begin
        adrHor  <= H_SYNC;
        lineLen <= pcntInc;
        pcnt    <= '0;
        firstH  <= 1'b1;
        toFired <= 1'b0;
      end else begin
        adrHor <= (adrHor == H_SIZE - 10'd1) ? 10'd0 : adrHor + 10'd1;
        pcnt   <= pcntInc;
        if (pcnt == SAT) toFired <= 1'b1;
      end
      if (hsFall) hsWid <= 10'd1;
      else if (!HS && hsWid != SAT) hsWid <= hsWid + 10'd1;
    end
  end

  // A line starting together with the VS fall belongs to the new frame.
  always_ff @(posedge ckVideo or negedge rstVideoN) begin
    if (!rstVideoN) begin
      adrVer     <= '0;
      lcnt       <= '0;
      frameLines <= '0;
      vsWid      <= '0;
    end else begin
      if (vsFall) adrVer <= V_SYNC;
      else if (hsFall) adrVer <= (adrVer == V_SIZE - 10'd1) ? 10'd0 : adrVer + 10'd1;
      if (vsFall) begin
        frameLines <= lcnt;
        lcnt       <= {9'd0, hsFall};
        vsWid      <= {9'd0, hsFall};
      end else if (hsFall) begin
        if (lcnt != SAT) lcnt <= lcnt + 10'd1;
        if (!VS && vsWid != SAT) vsWid <= vsWid + 10'd1;
      end
    end
  end

  always_ff @(posedge ckVideo or negedge rstVideoN) begin
    if (!rstVideoN) begin
      state          <= SEARCH;
      goodCnt        <= '0;
      frameBad       <= 1'b0;
      flgLocked      <= 1'b0;
      flgActiveVideo <= 1'b0;
    end else begin
      flgActiveVideo <= flgLocked & (adrHor < H_AL) & (adrVer < V_AF);
      if (vsFall) frameBad <= 1'b0;
      else if (anyEv) frameBad <= 1'b1;
      case (state)
        SEARCH: begin
          if (vsFall) begin
            state   <= ACQUIRE;
            goodCnt <= '0;
          end
        end
        ACQUIRE: begin
          if (vsFall) begin
            if (frameBad | anyEv) begin
              goodCnt <= '0;
            end else if (goodNext == LOCK_N) begin
              state     <= LOCKED;
              flgLocked <= 1'b1;
              goodCnt   <= goodNext;
            end else begin
              goodCnt <= goodNext;
            end
          end else if (anyEv) begin
            goodCnt <= '0;
          end
        end
        LOCKED: begin
          if (errHor | errVer) begin
            state     <= SEARCH;
            flgLocked <= 1'b0;
          end
        end
        default: begin
          state     <= SEARCH;
          flgLocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
`timescale 1ns/1ps
// Bench for vga_timing_monitor on a shrunken raster: random sync streams with
// injected faults, a timestamp-based reference model and a queue scoreboard.
module tb_vga_timing_monitor;

  localparam int H_SIZE = 40;
  localparam int H_AL   = 24;
  localparam int H_FP   = 4;
  localparam int H_PW   = 6;
  localparam int V_SIZE = 16;
  localparam int V_AF   = 10;
  localparam int V_FP   = 2;
  localparam int V_PW   = 2;
  localparam int LOCK_N = 2;

  logic       ckVideo = 1'b0;
  logic       rstVideoN;
  logic       HS, VS;
  logic [9:0] adrHor, adrVer, lineLen, frameLines;
  logic       flgActiveVideo, flgLocked, errHor, errVer;

  vga_timing_monitor #(
    .HOR_SIZE(H_SIZE), .HOR_AL(H_AL), .HOR_FP(H_FP), .HOR_PW(H_PW),
    .VER_SIZE(V_SIZE), .VER_AF(V_AF), .VER_FP(V_FP), .VER_PW(V_PW),
    .LOCK_FRAMES(LOCK_N)
  ) dut (
    .ckVideo(ckVideo), .rstVideoN(rstVideoN), .HS(HS), .VS(VS),
    .adrHor(adrHor), .adrVer(adrVer), .flgActiveVideo(flgActiveVideo),
    .flgLocked(flgLocked), .errHor(errHor), .errVer(errVer),
    .lineLen(lineLen), .frameLines(frameLines)
  );

  always #5 ckVideo = ~ckVideo;

  typedef struct {
    int adrH, adrV, lineLen, frameLines;
    bit act, lock, eh, ev;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   actCount = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 1023) ? 1023 : x;
  endfunction

  // Reference model: positions and widths derived from event timestamps/counts.
  int   mN, mLastHF, mHBase, mHfTotal, mHfAtVs, mVBase, mVsCoinc;
  int   mLockSt, mStreak, mLastErr, mPrevVs;
  bit   mSeenHF, mPrevHS, mPrevVS;
  exp_t mCur;

  task automatic modelInit();
    mN = 0; mLastHF = -1; mHBase = 0; mHfTotal = 0; mHfAtVs = 0;
    mVBase = 0; mVsCoinc = 0; mLockSt = 0; mStreak = 0;
    mLastErr = -1; mPrevVs = -1; mSeenHF = 0; mPrevHS = 1; mPrevVS = 1;
    mCur = '{default: 0};
  endtask

  task automatic step(input bit h, input bit v);
    exp_t nx;
    int   sinceHF, lc, hCur, vCur;
    bit   hf, hr, vf, vr, horEv, verEv, good;
    sinceHF = mN - mLastHF;
    lc      = sat(mHfTotal - mHfAtVs);
    hCur    = (mHBase + sinceHF - 1) % H_SIZE;
    vCur    = (mVBase + mHfTotal - mHfAtVs - mVsCoinc) % V_SIZE;
    hf = mPrevHS && !h;  hr = !mPrevHS && h;
    vf = mPrevVS && !v;  vr = !mPrevVS && v;
    horEv = (hf && mSeenHF && sat(sinceHF) != H_SIZE) || (hr && sat(sinceHF) != H_PW)
         || (sinceHF - 1 == 1023);
    verEv = (vf && mLockSt != 0 && lc != V_SIZE) || (vr && lc != V_PW);
    nx     = mCur;
    nx.eh  = horEv;
    nx.ev  = verEv;
    nx.act = mCur.lock && hCur < H_AL && vCur < V_AF;
    if (hf) nx.lineLen = sat(sinceHF);
    if (vf) nx.frameLines = lc;
    case (mLockSt)
      0: if (vf) begin mLockSt = 1; mStreak = 0; end
      1: if (vf) begin
           good = !(horEv || verEv) && mLastErr <= mPrevVs;
           mStreak = good ? mStreak + 1 : 0;
           if (mStreak >= LOCK_N) mLockSt = 2;
         end
      default: if (mCur.eh || mCur.ev) mLockSt = 0;
    endcase
    nx.lock = (mLockSt == 2);
    if (vf) mPrevVs = mN;
    if (horEv || verEv) mLastErr = mN;
    if (vf) begin mHfAtVs = mHfTotal; mVBase = V_AF + V_FP; mVsCoinc = hf; end
    if (hf) begin mLastHF = mN; mHBase = H_AL + H_FP; mSeenHF = 1; mHfTotal++; end
    mN++;
    nx.adrH = (mHBase + mN - mLastHF - 1) % H_SIZE;
    nx.adrV = (mVBase + mHfTotal - mHfAtVs - mVsCoinc) % V_SIZE;
    expQ.push_back(nx);
    mCur = nx; mPrevHS = h; mPrevVS = v;
  endtask

  task automatic drive(input bit h, input bit v);
    @(negedge ckVideo);
    HS = h; VS = v;
    step(h, v);
  endtask

  task automatic waitMon();
    @(posedge ckVideo); #2;
  endtask

  task automatic doReset();
    @(negedge ckVideo);
    rstVideoN = 1'b0; HS = 1'b1; VS = 1'b1;
    repeat (3) @(negedge ckVideo);
    chk("rst adrHor", adrHor, 0);
    chk("rst adrVer", adrVer, 0);
    chk("rst active", flgActiveVideo, 0);
    chk("rst locked", flgLocked, 0);
    chk("rst errHor", errHor, 0);
    chk("rst errVer", errVer, 0);
    chk("rst lineLen", lineLen, 0);
    chk("rst frameLines", frameLines, 0);
    rstVideoN = 1'b1;
    modelInit();
    step(1'b1, 1'b1);
  endtask

  // kind: 0 ideal, 1 line length=arg, 2 HS width=arg, 3 VS lines=arg,
  //       4 frame lines=arg, 5 HS stalled high arg extra clocks
  task automatic frame(input int kind, input int line, input int arg);
    int nLines, vpw, len, pw;
    bit vsv;
    nLines = (kind == 4) ? arg : V_SIZE;
    vpw    = (kind == 3) ? arg : V_PW;
    for (int ln = 0; ln < nLines; ln++) begin
      len = H_SIZE;
      pw  = H_PW;
      if (ln == line) begin
        if (kind == 1) len = arg;
        if (kind == 2) pw = arg;
        if (kind == 5) len = H_SIZE + arg;
      end
      vsv = !(ln >= V_AF + V_FP && ln < V_AF + V_FP + vpw);
      for (int k = 0; k < len; k++) drive(k >= pw, vsv);
    end
  endtask

  exp_t e;
  initial begin
    forever begin
      @(posedge ckVideo); #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("adrHor", adrHor, e.adrH);
        chk("adrVer", adrVer, e.adrV);
        chk("flgActiveVideo", flgActiveVideo, e.act);
        chk("flgLocked", flgLocked, e.lock);
        chk("errHor", errHor, e.eh);
        chk("errVer", errVer, e.ev);
        chk("lineLen", lineLen, e.lineLen);
        chk("frameLines", frameLines, e.frameLines);
        if (flgActiveVideo) actCount++;
      end
    end
  end

  int r, ln, d;
  initial begin
    rstVideoN = 1'b0; HS = 1'b1; VS = 1'b1;
    modelInit();
    doReset();

    repeat (4) frame(0, 0, 0);
    waitMon();
    chk("locked after ideal frames", flgLocked, 1);
    chk("ideal lineLen", lineLen, H_SIZE);
    chk("ideal frameLines", frameLines, V_SIZE);
    actCount = 0;
    frame(0, 0, 0);
    waitMon();
    chk("active cycles per frame", actCount, H_AL * V_AF);

    frame(1, 3, H_SIZE - 1);
    waitMon();
    chk("unlock after short line", flgLocked, 0);
    repeat (2) frame(0, 0, 0);
    waitMon();
    chk("relock after short line", flgLocked, 1);

    frame(3, 0, V_PW + 1);
    waitMon();
    chk("unlock after long VS", flgLocked, 0);
    repeat (3) frame(0, 0, 0);
    waitMon();
    chk("relock after long VS", flgLocked, 1);

    frame(5, 5, 1100);
    waitMon();
    chk("unlock after HS stall", flgLocked, 0);

    doReset();
    repeat (3) frame(0, 0, 0);
    waitMon();
    chk("lock after mid-frame reset", flgLocked, 1);

    for (int f = 0; f < 50; f++) begin
      r  = $urandom_range(0, 19);
      ln = $urandom_range(0, V_SIZE - 1);
      d  = $urandom_range(1, 3);
      if (r < 10)      frame(0, 0, 0);
      else if (r < 13) frame(1, ln, ($urandom_range(0, 1) == 1) ? H_SIZE + d : H_SIZE - d);
      else if (r < 15) frame(2, ln, ($urandom_range(0, 1) == 1) ? H_PW + 1 : H_PW - 1);
      else if (r < 17) frame(3, 0, ($urandom_range(0, 1) == 1) ? V_PW + 1 : V_PW - 1);
      else if (r < 19) frame(4, 0, ($urandom_range(0, 1) == 1) ? V_SIZE + 1 : V_SIZE - 1);
      else             frame(5, ln, 1100);
    end

    waitMon();
    chk("scoreboard drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
